// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRD bypassed read ports,
// and per-register pending bits that let decode stall on outstanding loads.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                regrst_ni,
  input  logic [NRD*AW-1:0]   rs_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic                wa_en_i,
  input  logic [AW-1:0]       wa_rd_i,
  input  logic [1:0]          wa_sel_i,
  input  logic [XLEN-1:0]     wa_alu_i,
  input  logic [XLEN-1:0]     wa_link_i,
  input  logic [XLEN-1:0]     wa_ld_i,
  input  logic                wb_en_i,
  input  logic [AW-1:0]       wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                pend_set_i,
  input  logic [AW-1:0]       pend_rd_i,
  input  logic                flush_i
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [XLEN-1:0] wa_data;
  logic            wa_we;
  logic            wb_we;

  always_comb begin
    unique case (wa_sel_i)
      2'd0:    wa_data = wa_alu_i;
      2'd1:    wa_data = wa_link_i;
      2'd2:    wa_data = wa_ld_i;
      default: wa_data = '0;
    endcase
  end

  assign wa_we = wa_en_i && (wa_rd_i != '0);
  assign wb_we = wb_en_i && (wb_rd_i != '0);

  // Port A is applied after port B so the younger instruction's data wins.
  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[wb_rd_i] = wb_data_i;
    if (wa_we) regs_d[wa_rd_i] = wa_data;
    regs_d[0] = '0;
  end

  // Later assignments take priority: set beats B-clear, flush beats everything.
  always_comb begin
    pend_d = pend_q;
    if (wb_we) pend_d[wb_rd_i] = 1'b0;
    if (pend_set_i && (pend_rd_i != '0)) pend_d[pend_rd_i] = 1'b1;
    if (flush_i) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge regrst_ni) begin
    if (!regrst_ni) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      logic [AW-1:0]   rs;
      logic [XLEN-1:0] val;
      logic            busy;
      rs   = rs_i[k*AW +: AW];
      val  = '0;
      busy = 1'b0;
      if (rs != '0) begin
        if (wa_en_i && (wa_rd_i == rs))      val = wa_data;
        else if (wb_en_i && (wb_rd_i == rs)) val = wb_data_i;
        else                                 val = regs_q[rs];
        busy = pend_q[rs] && !(wb_en_i && (wb_rd_i == rs));
      end
      if (regrst_ni) begin
        rdata_o[k*XLEN +: XLEN] = val;
        rbusy_o[k]              = busy;
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the core's single-write, dual-read integer register file.
- Configurable data width, register count and read-port count.
- Two write ports: port A for ALU/JALR writeback with an in-block source mux; port B for late load writeback.
- Same-cycle write-to-read bypass on every read port.
- Per-register pending (scoreboard) bits so decode can stall on outstanding loads.
- Sits between decode (reads, pending check) and the writeback stages.

Parameters:
- XLEN, 32, data width of each register and data port.
- NREG, 32, number of architectural registers; power of two, ≥2; index 0 is hardwired zero.
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREG), register-index width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- regrst_ni  in  1  asynchronous active-low reset.
- rs_i  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata_o  out  NRD*XLEN  packed read data, bypassed.
- rbusy_o  out  NRD  per-read-port pending flag for the addressed register.
- wa_en_i  in  1  port A write enable.
- wa_rd_i  in  AW  port A destination.
- wa_sel_i  in  2  port A source select: 0=wa_alu_i, 1=wa_link_i, 2=wa_ld_i, 3=reserved (writes zero).
- wa_alu_i  in  XLEN  ALU result.
- wa_link_i  in  XLEN  JAL/JALR link value.
- wa_ld_i  in  XLEN  single-cycle load data.
- wb_en_i  in  1  port B (late load) write enable.
- wb_rd_i  in  AW  port B destination.
- wb_data_i  in  XLEN  port B data.
- pend_set_i  in  1  mark pend_rd_i as pending (multi-cycle load issued).
- pend_rd_i  in  AW  register to mark.
- flush_i  in  1  synchronous clear of all pending bits.

Behaviour:
- Reset (regrst_ni=0, asynchronous): all registers and pending bits clear immediately. While reset is held:
  - writes and pending sets are ignored;
  - rdata_o=0 and rbusy_o=0 on all ports.
- Register 0: never written and never pending. A read of 0 always returns 0 with rbusy=0, even when a port writes rd=0 in the same cycle.
- Port A data: the wa_sel_i mux output. It is written at the rising edge when wa_en_i=1 and wa_rd_i≠0.
- Port B: wb_data_i is written at the rising edge when wb_en_i=1 and wb_rd_i≠0. It clears pending[wb_rd_i] at the same edge.
- Same-rd conflict: if A and B target the same rd in one cycle, port A data is stored (A is the younger instruction). Port B still clears the pending bit.
- Read path (combinational, zero-cycle bypass). Per port k:
  - rs=0 → 0;
  - else if wa_en_i and wa_rd_i==rs → port A mux value;
  - else if wb_en_i and wb_rd_i==rs → wb_data_i;
  - else the stored register.
- rbusy_o[k]: pending[rs] & ~(wb_en_i & wb_rd_i==rs). A load completing this cycle is visible as not busy with its data bypassed.
- Pending updates, in priority order at each edge:
  1. flush_i=1 → all bits clear; a pend_set_i in the same cycle is ignored.
  2. Otherwise pend_set_i with pend_rd_i≠0 sets the bit. Set beats a port B clear of the same register in the same cycle, because the new load is younger.
- Port A writes never change pending bits. Keeping WAW-safe sequencing is decode's job.
- Out-of-range addresses cannot occur, since NREG is a power of two.
- No internal latency beyond one edge: data written at edge N is readable from the array after edge N, and via bypass during the cycle before it.

Test Plan:
1. Reset release: write A rd=5 data 0xDEADBEEF, next cycle read rs0=5 → 0xDEADBEEF, rbusy=0. Assert regrst_ni low mid-cycle → rdata 0 immediately; after release, read 5 → 0.
2. Bypass and x0: wa_en=1, rd=7, sel=1, wa_link=0x100, rs0=rs1=7 in the same cycle → both rdata=0x100. wa_rd=0 with data 0x55 → read 0 gives 0.
3. Source mux: sel=0/1/2/3 with alu=0x11, link=0x22, ld=0x33 into rd=1..4 → reads 0x11, 0x22, 0x33, 0x0.
4. Scoreboard: pend_set rd=9 → rbusy=1 for rs=9 next cycle. Three cycles later wb_en rd=9 data 0xCAFE → rbusy=0 and rdata=0xCAFE in that cycle; stays 0xCAFE afterwards.
5. Conflicts:
   - A and B both to rd=3 (A=0x1, B=0x2) → stored 0x1 and pending[3] cleared.
   - pend_set rd=4 with wb rd=4 in one cycle → pending[4]=1 afterwards.
   - flush_i with pend_set rd=6 → pending[6]=0.
6. Parameter sweep: XLEN=64, NREG=16, NRD=3: write 0xFFFF_FFFF_0000_0001 to rd=15, read on all three ports → identical value. Verify no x0 write via either port.
